// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: shared state encoding, pattern-entry type and default sizes
// for the scan chain controller.
package scan_ctrl_pkg;

    localparam int DEF_CHAIN_LEN = 4;
    localparam int DEF_FCNT_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SHIFT,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [DEF_CHAIN_LEN-1:0] data;
        logic [DEF_CHAIN_LEN-1:0] exp;
        logic                     last;
    } pat_entry_t;

endpackage

// File: rtl/scan_misr.sv
// scan_misr: multiple-input signature register; folds one response word into
// the signature per enabled cycle, with a synchronous clear.
module scan_misr #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(4'h9)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_sig
);

    logic [WIDTH-1:0] r_sig;
    logic [WIDTH-1:0] w_feedback;

    assign w_feedback = r_sig[WIDTH-1] ? POLY : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sig <= '0;
        end else if (i_clear) begin
            r_sig <= '0;
        end else if (i_enable) begin
            r_sig <= {r_sig[WIDTH-2:0], 1'b0} ^ w_feedback ^ i_data;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: scan load / single-cycle capture / overlapped unload sequencer
// with response compare. Define SCAN_MISR_EN to add MISR signature compaction.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int                   CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int                   FCNT_W    = DEF_FCNT_W,
    parameter logic [CHAIN_LEN-1:0] MISR_POLY = CHAIN_LEN'(4'h9)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic [CHAIN_LEN-1:0] pat_exp,
    input  logic                 pat_last,
    output logic                 scan_en,
    output logic                 scan_in,
    input  logic                 chain_so,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [FCNT_W-1:0]    fail_cnt,
    output logic [CHAIN_LEN-1:0] signature
);

    localparam int               CNT_W    = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef struct packed {
        logic [CHAIN_LEN-1:0] data;
        logic [CHAIN_LEN-1:0] exp;
        logic                 last;
    } entry_t;

    state_t               r_state;
    logic                 r_load;
    logic                 r_unload;
    logic [CNT_W-1:0]     r_cnt;
    entry_t               r_nxt;
    logic                 r_nxtFull;
    logic                 r_lastSeen;
    entry_t               r_cur;
    logic [CHAIN_LEN-1:0] r_prevExp;
    logic                 r_prevLast;
    logic [CHAIN_LEN-2:0] r_resp;
    logic                 r_scanEn;
    logic                 r_scanIn;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_fail;
    logic [FCNT_W-1:0]    r_failCnt;

    logic                 w_accept;
    entry_t               w_incoming;
    entry_t               w_waitEntry;
    logic [CHAIN_LEN-1:0] w_respFull;
    logic [CHAIN_LEN-1:0] w_ldShifted;
    logic                 w_lastCycle;
    logic                 w_compare;

    // Once the session's last pattern is buffered no further patterns are taken.
    assign pat_ready   = r_busy & ~r_nxtFull & ~r_lastSeen;
    assign w_accept    = pat_valid & pat_ready;
    assign w_incoming  = '{data: pat_data, exp: pat_exp, last: pat_last};
    assign w_waitEntry = r_nxtFull ? r_nxt : w_incoming;
    assign w_respFull  = {r_resp, chain_so};
    assign w_ldShifted = r_cur.data << r_cnt;
    assign w_lastCycle = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);
    assign w_compare   = w_lastCycle & r_unload;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_load     <= 1'b0;
            r_unload   <= 1'b0;
            r_cnt      <= '0;
            r_nxt      <= '0;
            r_nxtFull  <= 1'b0;
            r_lastSeen <= 1'b0;
            r_cur      <= '0;
            r_prevExp  <= '0;
            r_prevLast <= 1'b0;
            r_resp     <= '0;
            r_scanEn   <= 1'b0;
            r_scanIn   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_failCnt  <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_accept) begin
                r_nxt     <= w_incoming;
                r_nxtFull <= 1'b1;
                if (pat_last) begin
                    r_lastSeen <= 1'b1;
                end
            end

            if (w_compare && (w_respFull != r_prevExp)) begin
                r_fail <= 1'b1;
                if (r_failCnt != '1) begin
                    r_failCnt <= r_failCnt + FCNT_W'(1);
                end
            end

            // Outputs are registered, so each branch sets them for the state being entered.
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_WAIT;
                        r_busy     <= 1'b1;
                        r_scanEn   <= 1'b1;
                        r_scanIn   <= 1'b0;
                        r_fail     <= 1'b0;
                        r_failCnt  <= '0;
                        r_nxtFull  <= 1'b0;
                        r_lastSeen <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    if (r_nxtFull || w_accept) begin
                        r_state   <= ST_SHIFT;
                        r_cur     <= w_waitEntry;
                        r_nxtFull <= 1'b0;
                        r_load    <= 1'b1;
                        r_unload  <= 1'b0;
                        r_cnt     <= '0;
                        r_scanEn  <= 1'b1;
                        r_scanIn  <= w_waitEntry.data[CHAIN_LEN-1];
                    end
                end

                ST_SHIFT: begin
                    if (r_unload) begin
                        r_resp <= w_respFull[CHAIN_LEN-2:0];
                    end
                    if (!w_lastCycle) begin
                        r_cnt    <= r_cnt + CNT_W'(1);
                        r_scanIn <= r_load & w_ldShifted[CHAIN_LEN-2];
                    end else if (r_load) begin
                        r_state  <= ST_CAPTURE;
                        r_scanEn <= 1'b0;
                        r_scanIn <= 1'b0;
                    end else if (r_prevLast) begin
                        r_state  <= ST_DONE;
                        r_scanEn <= 1'b0;
                        r_scanIn <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_state  <= ST_WAIT;
                        r_scanEn <= 1'b1;
                        r_scanIn <= 1'b0;
                    end
                end

                ST_CAPTURE: begin
                    r_state    <= ST_SHIFT;
                    r_prevExp  <= r_cur.exp;
                    r_prevLast <= r_cur.last;
                    r_unload   <= 1'b1;
                    r_cnt      <= '0;
                    r_scanEn   <= 1'b1;
                    if (r_nxtFull && !r_cur.last) begin
                        r_load    <= 1'b1;
                        r_cur     <= r_nxt;
                        r_nxtFull <= 1'b0;
                        r_scanIn  <= r_nxt.data[CHAIN_LEN-1];
                    end else begin
                        r_load   <= 1'b0;
                        r_scanIn <= 1'b0;
                    end
                end

                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_scanEn   <= 1'b0;
                    r_scanIn   <= 1'b0;
                    r_lastSeen <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign scan_en  = r_scanEn;
    assign scan_in  = r_scanIn;
    assign busy     = r_busy;
    assign done     = r_done;
    assign fail     = r_fail;
    assign fail_cnt = r_failCnt;

`ifdef SCAN_MISR_EN
    logic                 w_sessionStart;
    logic [CHAIN_LEN-1:0] w_sig;

    assign w_sessionStart = (r_state == ST_IDLE) && start;

    scan_misr #(
        .WIDTH (CHAIN_LEN),
        .POLY  (MISR_POLY)
    ) u_misr (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_sessionStart),
        .i_enable (w_compare),
        .i_data   (w_respFull),
        .o_sig    (w_sig)
    );

    assign signature = w_sig;
`else
    // Without compaction the signature reads as zero; the polynomial has no effect.
    assign signature = MISR_POLY & {CHAIN_LEN{1'b0}};
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: directed and randomized sessions against a behavioural
// scan chain plus a response/fail-count/signature reference model.
`timescale 1ns/1ps
module tb_scan_chain_ctrl;

    localparam int           N    = 4;
    localparam int           FW   = 8;
    localparam logic [N-1:0] POLY = 4'h9;
    localparam int           FMAX = (1 << FW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          pat_valid = 1'b0;
    logic          pat_last = 1'b0;
    logic [N-1:0]  pat_data = '0;
    logic [N-1:0]  pat_exp = '0;
    logic          pat_ready, scan_en, scan_in, chain_so, busy, done, fail;
    logic [FW-1:0] fail_cnt;
    logic [N-1:0]  signature;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int doneCount = 0;

    bit           captureHold = 1'b1;
    logic [N-1:0] captureVal = '0;
    logic [N-1:0] chain = '0;
    logic         logEn[int];
    logic         logIn[int];
    int           captureQ[$];

    int           acc, a0, a1, a2, dc, base;
    logic [N-1:0] d0, d1, expSig;
    logic [N-1:0] pd[3];
    logic [N-1:0] pe[3];

    scan_chain_ctrl #(
        .CHAIN_LEN (N),
        .FCNT_W    (FW),
        .MISR_POLY (POLY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_data  (pat_data),
        .pat_exp   (pat_exp),
        .pat_last  (pat_last),
        .scan_en   (scan_en),
        .scan_in   (scan_in),
        .chain_so  (chain_so),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_cnt  (fail_cnt),
        .signature (signature)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural chain: shifts MSB-ward when enabled, otherwise captures or holds.
    always @(posedge clk) begin
        if (scan_en) chain <= {chain[N-2:0], scan_in};
        else if (!captureHold) chain <= captureVal;
    end
    assign chain_so = chain[N-1];

    always @(negedge clk) begin
        logEn[cyc] = scan_en;
        logIn[cyc] = scan_in;
        if (done === 1'b1) doneCount++;
        if (busy === 1'b1 && scan_en === 1'b0 && done === 1'b0) captureQ.push_back(cyc);
    end

    function automatic logic [N-1:0] misrStep(input logic [N-1:0] s, input logic [N-1:0] r);
        logic [N-1:0] sh;
        sh = s << 1;
        if (s[N-1]) sh = sh ^ POLY;
        return sh ^ r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] d, input logic [N-1:0] e, input logic l, output int accCyc);
        pat_data  = d;
        pat_exp   = e;
        pat_last  = l;
        pat_valid = 1'b1;
        accCyc    = -1;
        for (int k = 0; k < 400; k++) begin
            if (pat_ready === 1'b1) begin
                accCyc = cyc;
                break;
            end
            @(negedge clk);
        end
        checkOutput("accepted", 32'(accCyc >= 0), 32'd1);
        @(negedge clk);
        pat_valid = 1'b0;
    endtask

    task automatic startSession(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        checkOutput({tag, "_fail_cleared"}, {fail_cnt, fail}, 32'd0);
        checkOutput({tag, "_sig_cleared"}, 32'(signature), 32'd0);
    endtask

    task automatic waitDone(input int budget, output int doneCyc);
        doneCyc = -1;
        for (int k = 0; k < budget; k++) begin
            if (done === 1'b1) begin
                doneCyc = cyc;
                break;
            end
            @(negedge clk);
        end
        checkOutput("done_seen", 32'(doneCyc >= 0), 32'd1);
        @(negedge clk);
        checkOutput("done_one_cycle", {busy, done}, 32'd0);
    endtask

    task automatic runSession(input int nPat, input int maxGap, input bit pokeStart, input bit allBad, input string tag);
        logic [N-1:0] d, e, r, sig;
        int cnt, accCyc, doneCyc;
        startSession(tag);
        sig = '0;
        cnt = 0;
        for (int p = 0; p < nPat; p++) begin
            d = N'($urandom);
            r = captureHold ? d : captureVal;
            if (allBad) e = ~r;
            else e = ($urandom_range(0, 1) == 1) ? r : N'($urandom);
            if (e != r && cnt < FMAX) cnt++;
            sig = misrStep(sig, r);
            repeat ($urandom_range(0, maxGap)) @(negedge clk);
            applyStimulus(d, e, p == nPat - 1, accCyc);
            if (pokeStart && p == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        waitDone(nPat * 25 + 100, doneCyc);
        checkOutput({tag, "_fail"}, 32'(fail), 32'(cnt != 0));
        checkOutput({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(cnt));
`ifdef SCAN_MISR_EN
        checkOutput({tag, "_sig"}, 32'(signature), 32'(sig));
`else
        checkOutput({tag, "_sig"}, 32'(signature), 32'd0);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_ctrl", {pat_ready, scan_en, scan_in, busy, done, fail}, 32'd0);
        checkOutput("rst_cnt_sig", {fail_cnt, signature}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Loopback: response equals stimulus, single pattern.
        captureHold = 1'b1;
        startSession("lb");
        d0 = 4'b1000;
        applyStimulus(d0, 4'b1000, 1'b1, acc);
        waitDone(100, dc);
        checkOutput("lb_done_cyc", dc, acc + 2 * N + 2);
        for (int i = 0; i < N; i++) begin
            checkOutput("lb_scan_in", 32'(logIn[acc + 1 + i]), 32'(d0[N - 1 - i]));
            checkOutput("lb_scan_en", 32'(logEn[acc + 1 + i]), 32'd1);
        end
        checkOutput("lb_capture_en", 32'(logEn[acc + N + 1]), 32'd0);
        checkOutput("lb_fail", {fail_cnt, fail}, 32'd0);

        // Mismatch then a clean session clears the sticky results.
        captureHold = 1'b0;
        captureVal  = 4'hA;
        startSession("mm1");
        applyStimulus(N'($urandom), 4'h5, 1'b1, acc);
        waitDone(100, dc);
        checkOutput("mm1_fail", 32'(fail), 32'd1);
        checkOutput("mm1_fail_cnt", 32'(fail_cnt), 32'd1);
        startSession("mm2");
        applyStimulus(N'($urandom), 4'hA, 1'b1, acc);
        waitDone(100, dc);
        checkOutput("mm2_fail", 32'(fail), 32'd0);
        checkOutput("mm2_fail_cnt", 32'(fail_cnt), 32'd0);

        // Overlap: three back-to-back patterns, middle one mismatching.
        captureHold = 1'b1;
        for (int p = 0; p < 3; p++) begin
            pd[p] = N'($urandom);
            pe[p] = (p == 1) ? ~pd[p] : pd[p];
        end
        startSession("ov");
        captureQ.delete();
        applyStimulus(pd[0], pe[0], 1'b0, a0);
        applyStimulus(pd[1], pe[1], 1'b0, a1);
        applyStimulus(pd[2], pe[2], 1'b1, a2);
        checkOutput("ov_accept1", a1, a0 + 1);
        checkOutput("ov_accept2", a2, a0 + N + 2);
        pat_data  = N'($urandom);
        pat_last  = 1'b0;
        pat_valid = 1'b1;
        while (cyc < a0 + 3 * N) @(negedge clk);
        checkOutput("ov_trailing_ready", 32'(pat_ready), 32'd0);
        pat_valid = 1'b0;
        waitDone(100, dc);
        checkOutput("ov_done_cyc", dc, a0 + 2 * N + 2 + 2 * (N + 1));
        checkOutput("ov_captures", captureQ.size(), 32'd3);
        for (int c = 0; c < 3 && c < captureQ.size(); c++) begin
            checkOutput("ov_capture_cyc", captureQ[c], a0 + (c + 1) * (N + 1));
        end
        for (int i = 0; i < N; i++) begin
            checkOutput("ov_unload1_in", 32'(logIn[a0 + N + 2 + i]), 32'(pd[1][N - 1 - i]));
            checkOutput("ov_unload2_in", 32'(logIn[a0 + 2 * N + 3 + i]), 32'(pd[2][N - 1 - i]));
            checkOutput("ov_unload3_in", 32'(logIn[a0 + 3 * N + 4 + i]), 32'd0);
        end
        checkOutput("ov_fail", {fail_cnt, fail}, {FW'(1), 1'b1});

        // Starvation: second pattern arrives during the first unload.
        captureHold = 1'b1;
        d0 = N'($urandom);
        d1 = N'($urandom);
        startSession("st");
        applyStimulus(d0, ~d0, 1'b0, a0);
        while (cyc < a0 + 6) @(negedge clk);
        applyStimulus(d1, ~d1, 1'b1, a1);
        checkOutput("st_accept1", a1, a0 + 6);
        waitDone(100, dc);
        checkOutput("st_done_cyc", dc, a0 + 4 * N + 4);
        for (int i = 0; i < N; i++) begin
            checkOutput("st_unload_only", {logEn[a0 + N + 2 + i], logIn[a0 + N + 2 + i]}, 32'b10);
            checkOutput("st_reload_in", 32'(logIn[a0 + 2 * N + 3 + i]), 32'(d1[N - 1 - i]));
        end
        checkOutput("st_wait_pins", {logEn[a0 + 2 * N + 2], logIn[a0 + 2 * N + 2]}, 32'b10);
        checkOutput("st_fail_cnt", 32'(fail_cnt), 32'd2);

        // MISR: two responses of 4'hA, repeated across a restart.
        captureHold = 1'b0;
        captureVal  = 4'hA;
`ifdef SCAN_MISR_EN
        expSig = misrStep(misrStep('0, 4'hA), 4'hA);
`else
        expSig = '0;
`endif
        for (int rep = 0; rep < 2; rep++) begin
            startSession("misr");
            applyStimulus(N'($urandom), N'($urandom), 1'b0, acc);
            applyStimulus(N'($urandom), N'($urandom), 1'b1, acc);
            waitDone(100, dc);
            checkOutput("misr_sig", 32'(signature), 32'(expSig));
        end

        // Mid-session reset during the second pattern's unload.
        captureHold = 1'b0;
        captureVal  = 4'hA;
        startSession("mr");
        applyStimulus(N'($urandom), ~4'hA, 1'b0, a0);
        applyStimulus(N'($urandom), N'($urandom), 1'b1, a1);
        while (cyc < a0 + 3 * N) @(negedge clk);
        checkOutput("mr_pre_fail", 32'(fail), 32'd1);
        base = doneCount;
        rst = 1'b0;
        #1;
        checkOutput("mr_ctrl", {pat_ready, scan_en, scan_in, busy, done, fail}, 32'd0);
        checkOutput("mr_cnt_sig", {fail_cnt, signature}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("mr_no_done", doneCount, base);
        checkOutput("mr_idle", {busy, pat_ready, scan_en}, 32'd0);

        // Randomized sessions, one with a start pulse that must be ignored.
        for (int s = 0; s < 6; s++) begin
            captureHold = ($urandom_range(0, 1) == 1);
            captureVal  = N'($urandom);
            runSession((s == 2) ? 3 : $urandom_range(1, 5), $urandom_range(0, 8), s == 2, 1'b0, "rnd");
        end

        // Failure counter saturation.
        captureHold = 1'b0;
        captureVal  = N'($urandom);
        runSession(FMAX + 5, 0, 1'b0, 1'b1, "sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Scan test controller that sits directly upstream of the scan-chain stage and drives its `scan_en`/`scan_in` pins. It also consumes that stage's `scan_out`. The block accepts test patterns with expected responses over a valid/ready interface, serially loads each pattern, issues one capture cycle, and unloads the response. Each response is compared to its expected value, and the unload overlaps the next load whenever a pattern is already buffered.

## Interface
- `CHAIN_LEN`, 4, scan chain length in cells; also the pattern and response width (≥2)
- `FCNT_W`, 8, width of the failure counter
- `MISR_POLY`, 4'h9, MISR feedback taps, CHAIN_LEN wide; used only with `SCAN_MISR_EN`

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin test session; ignored while `busy`
- `pat_valid`  in  1  pattern offered
- `pat_ready`  out  1  pattern buffer empty
- `pat_data`  in  CHAIN_LEN  stimulus vector
- `pat_exp`  in  CHAIN_LEN  expected response vector
- `pat_last`  in  1  final pattern of session
- `scan_en`  out  1  to chain: 1 = shift, 0 = functional/capture
- `scan_in`  out  1  to chain serial input
- `chain_so`  in  1  from chain `scan_out`
- `busy`  out  1  session active
- `done`  out  1  one-cycle end-of-session pulse
- `fail`  out  1  sticky mismatch flag; cleared by `start`
- `fail_cnt`  out  FCNT_W  saturating mismatch count; cleared by `start`
- `signature`  out  CHAIN_LEN  MISR signature

## Operation
- **Buffer:**
  - One-entry pattern buffer `nxt` holds {data, exp, last}.
  - `pat_ready` = `busy` and `nxt` empty.
  - A handshake (`pat_valid`&&`pat_ready`) fills `nxt` in any busy state.
- **States:** IDLE, WAIT, SHIFT, CAPTURE, DONE.
- **IDLE:**
  - `scan_en`=0, `scan_in`=0.
  - `start` → WAIT; clears `fail`, `fail_cnt`, `signature`.
- **WAIT:**
  - `scan_en`=1, `scan_in`=0 (chain contents are don't-care here).
  - When `nxt` is full → SHIFT with load active; `cur` ← `nxt`, and `nxt` empties.
- **SHIFT:**
  - `scan_en`=1; runs for CHAIN_LEN cycles, counter 0..CHAIN_LEN-1.
  - Load active: `scan_in` = `cur.data[CHAIN_LEN-1-cnt]` (MSB first). Otherwise `scan_in`=0.
  - Unload active: each cycle `resp` ← {`resp[CHAIN_LEN-2:0]`, `chain_so`}.
  - Last cycle, with unload active: compare the completed `resp` against `prev.exp`. On mismatch, set `fail` and increment `fail_cnt` (saturating).
  - Exit when load active → CAPTURE. Exit when unload-only and `prev.last` → DONE. Exit when unload-only and not last → WAIT.
- **CAPTURE:**
  - One cycle, `scan_en`=0, `scan_in`=0; `prev` ← `cur`.
  - Next is always SHIFT with unload active.
  - If `nxt` is full and `cur.last`=0: load is also active, and `cur` ← `nxt`.
  - Otherwise the state is unload-only.
- **DONE:** `done`=1 for one cycle, `scan_en`=0, then IDLE.
- **busy:** 1 in WAIT, SHIFT, CAPTURE and DONE.
- **Stalls:** never occur while the chain holds live data. The only stall point is WAIT.
- **Trailing patterns:** patterns offered after a `pat_last` pattern are not accepted, because `pat_ready` is held at 0 once `last` is buffered.

## Timing
- **Reset values:** all outputs 0, state IDLE, buffers empty.
- **Mid-operation reset:** asserting `rst` aborts immediately, with no `done`.
- **Single pattern (`nxt` empty), accepted in cycle T:**
  - SHIFT-load T+1..T+N.
  - CAPTURE T+N+1.
  - SHIFT-unload T+N+2..T+2N+1.
  - `done` at T+2N+2 (T+10 for N=4).
- **Back-to-back patterns:** each additional buffered pattern costs N+1 cycles.
- **Updates:** `fail`, `fail_cnt` and `signature` update on the edge ending the last unload cycle.
- **Sampling:** `chain_so` is sampled on the same edge that shifts the chain.
- **start:** `start` is registered on the edge it is sampled; `start` during DONE is ignored.

## Configuration
- **With `SCAN_MISR_EN` defined:**
  - Instantiates a CHAIN_LEN-bit MISR.
  - Per completed response: `sig` ← ({`sig[N-2:0]`,0} ^ (`sig[N-1]` ? `MISR_POLY` : 0)) ^ `resp`.
  - `signature` = `sig`.
- **Without `SCAN_MISR_EN`:** `signature` is tied to 0 and `MISR_POLY` is unused. Comparison logic is unaffected.

## Structure
- **Package `scan_ctrl_pkg`:** state enum, pattern-entry struct {data, exp, last}, default CHAIN_LEN and FCNT_W constants.
- **Sub-module `scan_misr`:** parameterised by width and polynomial, with clear and enable inputs; instantiated only under `SCAN_MISR_EN`.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles mid-SHIFT → all outputs 0, state IDLE; `done` never pulses.
- **Loopback order** (bench chain holds contents on capture): pattern 4'b1000, exp 4'b1000, last → `scan_in` sequence 1,0,0,0; `fail`=0; `done` at accept+10.
- **Mismatch** (bench capture loads 4'hA): exp 4'h5 → `fail`=1, `fail_cnt`=1. A second session with exp 4'hA → `fail`=0, `fail_cnt`=0.
- **Overlap:** three patterns offered back-to-back → CAPTURE cycles 5 apart; unload `scan_in` carries the next pattern; `done` at first accept+20.
- **Starvation:** second pattern offered 6 cycles late → unload-only SHIFT, then WAIT with `scan_en`=1, `scan_in`=0, then resumes; both responses are checked.
- **MISR** (`SCAN_MISR_EN`, capture 4'hA, two patterns) → `signature` 4'h7, and the same value again after re-`start`; without the macro, `signature`=0.
